count_monitor: RTL and testbench
================================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter W, default 10: sample width.
REQ-002 SHALL have parameter WRAP_W, default 8: wrap-counter width.
REQ-003 SHALL have parameter DEPTH, default 4: event-FIFO depth, power of two, minimum 2.
REQ-004 SHALL have port clk  input  1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1: in_count carries a sample this cycle.
REQ-007 SHALL have port in_count  input  W: sampled counter value.
REQ-008 SHALL have port evt_valid  output  1: event available at FIFO head.
REQ-009 SHALL have port evt_ready  input  1: consumer accepts head event.
REQ-010 SHALL have port evt_kind  output  2: 01 WRAP, 10 STEP_ERR, 11 RANGE_ERR.
REQ-011 SHALL have port evt_count  output  W: sample that caused the event.
REQ-012 SHALL have port wrap_cnt  output  WRAP_W: number of wraps seen, saturating.
REQ-013 SHALL have port err  output  1: sticky fault flag.
REQ-014 SHALL have port ovf  output  1: sticky flag, event lost because FIFO full.

Function
REQ-015 SHALL define LIMIT = 2^(W-1)-1; legal samples are 0..LIMIT.
REQ-016 SHALL implement FSM IDLE, TRACK, FAULT; samples are only considered when in_valid=1.
REQ-017 In IDLE, a sample <= LIMIT SHALL be stored as prev, with transition to TRACK; a sample > LIMIT SHALL push RANGE_ERR, set err, and transition to FAULT.
REQ-018 In TRACK, expected SHALL be 0 if prev==LIMIT, else prev+1, computed in W bits.
REQ-019 In TRACK, sample > LIMIT SHALL push RANGE_ERR and go to FAULT; this check takes priority over the step check.
REQ-020 In TRACK, sample != expected SHALL push STEP_ERR, set err, and go to FAULT.
REQ-021 In TRACK, a sample equal to expected SHALL update prev; if it is 0 following prev==LIMIT, it SHALL also push WRAP and increment wrap_cnt, holding at all-ones.
REQ-022 In FAULT, all samples SHALL be ignored; only reset exits FAULT.
REQ-023 An event SHALL appear at evt_valid no earlier than the cycle after its sample; with the FIFO empty, the latency is exactly 1 cycle.
REQ-024 The FIFO SHALL pop on evt_valid && evt_ready; evt_kind and evt_count SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-025 A push while full with no pop that cycle SHALL drop the event and set ovf; a push while full with a pop that cycle SHALL be accepted.
REQ-026 Occupancy SHALL never exceed DEPTH; evt_valid SHALL be 0 whenever the FIFO is empty.

Reset
REQ-027 On rst_n=0 at a clock edge, the block SHALL enter IDLE and clear prev, the FIFO, wrap_cnt, err and ovf; all outputs SHALL read 0 the next cycle.
REQ-028 Reset asserted mid-operation SHALL discard pending events; in_valid SHALL be ignored during the reset cycle.

Configuration
REQ-029 With COUNT_MON_PROPS_EN defined, the block SHALL compile in immediate/concurrent assertions: evt payload stable under backpressure, occupancy <= DEPTH, wrap_cnt non-decreasing, err implies state FAULT, and state FAULT implies err.
REQ-030 Without COUNT_MON_PROPS_EN, no assertions SHALL be compiled; functional behaviour SHALL be identical in both builds.

Structure
REQ-031 Package count_mon_pkg SHALL hold the FSM state enum, the evt_kind enum (WRAP, STEP_ERR, RANGE_ERR), and the default DEPTH constant.
REQ-032 The event FIFO SHALL be the single sub-module count_mon_fifo, parameterised by payload width and DEPTH.

Verification (W=4, LIMIT=7, DEPTH=4)
REQ-033 Drive samples 0..7, 0, 1 with evt_ready=1 -> one WRAP with evt_count=0 one cycle after the 0 sample; wrap_cnt=1; err=0.
REQ-034 Drive 3, 4, 6 -> STEP_ERR with evt_count=6; err=1; state FAULT; a following 7 produces no event.
REQ-035 Drive 9 first after reset -> RANGE_ERR with evt_count=9; err=1.
REQ-036 Hold evt_ready=0, cause 5 wraps -> 4 events queued, ovf=1, head payload stable; release ready -> exactly 4 pops.
REQ-037 With WRAP_W=2, cause 5 wraps -> wrap_cnt saturates at 3.
REQ-038 Assert rst_n=0 with 2 events queued and err=1 -> next cycle evt_valid=0, err=0, ovf=0, wrap_cnt=0, state IDLE.

Source files
------------

// File: rtl/count_mon_pkg.sv
// -----------------------------------------------------------------------------
// count_mon_pkg
// Shared types and constants for the count_monitor block:
//   state_t    - monitor FSM state (IDLE / TRACK / FAULT)
//   evt_kind_t - event code carried through the event FIFO
//   DEFAULT_DEPTH - default event-FIFO depth
// -----------------------------------------------------------------------------
package count_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // EVT_NONE never enters the FIFO; it is the idle value of the push path.
    typedef enum logic [1:0] {
        EVT_NONE      = 2'b00,
        EVT_WRAP      = 2'b01,
        EVT_STEP_ERR  = 2'b10,
        EVT_RANGE_ERR = 2'b11
    } evt_kind_t;

    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/count_mon_fifo.sv
// -----------------------------------------------------------------------------
// count_mon_fifo
// Small synchronous FIFO holding monitor events. A push while full is
// accepted only when a pop happens in the same cycle; the caller decides
// what to do with a refused push.
// Optional checker: COUNT_MON_PROPS_EN (occupancy never exceeds DEPTH).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   push, push_data     - write request and payload
//   pop                 - remove head (ignored when empty)
//   full, empty         - status
//   head_data           - payload at head, forced to 0 while empty
// -----------------------------------------------------------------------------
module count_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      level;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle;
    // the read sees the old contents because the write lands at the edge.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    // Stale storage is hidden so the outputs read 0 whenever nothing is queued.
    assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

`ifdef COUNT_MON_PROPS_EN
    always @(posedge clk) begin
        if (rst_n) begin
            assert (level <= DEPTH_L) else $error("fifo occupancy above DEPTH");
        end
    end
`else
    // Checker-free build.
`endif

endmodule

// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
// Watches a free-running counter that should step by one and wrap from
// LIMIT = 2^(W-1)-1 back to 0. Wraps, step errors and out-of-range samples
// are queued as events; any error parks the FSM in FAULT until reset.
// Optional checkers: COUNT_MON_PROPS_EN.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid, in_count    - sample strobe and counter value
//   evt_valid, evt_ready  - event handshake (pop on valid && ready)
//   evt_kind, evt_count   - head event code and causing sample
//   wrap_cnt              - saturating wrap count
//   err                   - sticky fault flag
//   ovf                   - sticky flag, an event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int W      = 10,
    parameter int WRAP_W = 8,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [W-1:0]      in_count,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_kind,
    output logic [W-1:0]      evt_count,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic              ovf
);

    localparam logic [W-1:0] LIMIT = {1'b0, {(W-1){1'b1}}};

    state_t            state_reg, state_next;
    logic [W-1:0]      prev_reg, prev_next;
    logic [W-1:0]      expected;
    logic [WRAP_W-1:0] wrap_cnt_reg;
    logic              err_reg;
    logic              ovf_reg;
    logic              push;
    evt_kind_t         push_kind;
    logic              wrap_hit;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [W+1:0]      head_data;

    // ---- state register ----------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            prev_reg     <= '0;
            wrap_cnt_reg <= '0;
            err_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            if (wrap_hit && (wrap_cnt_reg != '1))
                wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
            // err mirrors entry into FAULT, which only reset leaves.
            if (state_next == ST_FAULT)
                err_reg <= 1'b1;
            if (push && fifo_full && !pop)
                ovf_reg <= 1'b1;
        end
    end

    // ---- next-state / event decision ---------------------------------------
    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        push       = 1'b0;
        push_kind  = EVT_NONE;
        wrap_hit   = 1'b0;
        expected   = (prev_reg == LIMIT) ? '0 : prev_reg + W'(1);
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_count > LIMIT) begin
                        push       = 1'b1;
                        push_kind  = EVT_RANGE_ERR;
                        state_next = ST_FAULT;
                    end else begin
                        prev_next  = in_count;
                        state_next = ST_TRACK;
                    end
                end
            end
            ST_TRACK: begin
                if (in_valid) begin
                    // Range is checked before the step so an illegal value
                    // is always reported as such.
                    if (in_count > LIMIT) begin
                        push       = 1'b1;
                        push_kind  = EVT_RANGE_ERR;
                        state_next = ST_FAULT;
                    end else if (in_count != expected) begin
                        push       = 1'b1;
                        push_kind  = EVT_STEP_ERR;
                        state_next = ST_FAULT;
                    end else begin
                        prev_next = in_count;
                        if (prev_reg == LIMIT) begin
                            push      = 1'b1;
                            push_kind = EVT_WRAP;
                            wrap_hit  = 1'b1;
                        end
                    end
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---- outputs -----------------------------------------------------------
    always_comb begin
        evt_valid = !fifo_empty;
        pop       = !fifo_empty && evt_ready;
        evt_kind  = head_data[W+1:W];
        evt_count = head_data[W-1:0];
        wrap_cnt  = wrap_cnt_reg;
        err       = err_reg;
        ovf       = ovf_reg;
    end

    count_mon_fifo #(
        .WIDTH (W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_kind, in_count}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

`ifdef COUNT_MON_PROPS_EN
    assert property (@(posedge clk) disable iff (!rst_n)
        (evt_valid && !evt_ready) |=> ($stable(evt_kind) && $stable(evt_count)))
        else $error("event payload changed under backpressure");

    assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> (wrap_cnt >= $past(wrap_cnt)))
        else $error("wrap_cnt decreased");

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!err_reg || (state_reg == ST_FAULT)) else $error("err without FAULT");
            assert ((state_reg != ST_FAULT) || err_reg) else $error("FAULT without err");
        end
    end
`else
    // Checker-free build.
`endif

endmodule

// File: tb/tb_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_monitor
// Directed bench for count_monitor with W=4 (LIMIT=7), DEPTH=4. A second
// instance with WRAP_W=2 shares the stimulus to observe wrap_cnt saturation.
// -----------------------------------------------------------------------------
module tb_count_monitor;
    import count_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_count;
    logic       evt_ready;

    logic       evt_valid,  evt_valid2;
    logic [1:0] evt_kind,   evt_kind2;
    logic [3:0] evt_count,  evt_count2;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt2;
    logic       err,  err2;
    logic       ovf,  ovf2;

    int checks   = 0;
    int failures = 0;
    int pops;

    always #5 clk = ~clk;

    count_monitor #(.W(4), .WRAP_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_kind  (evt_kind),
        .evt_count (evt_count),
        .wrap_cnt  (wrap_cnt),
        .err       (err),
        .ovf       (ovf)
    );

    count_monitor #(.W(4), .WRAP_W(2), .DEPTH(4)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .evt_valid (evt_valid2),
        .evt_ready (evt_ready),
        .evt_kind  (evt_kind2),
        .evt_count (evt_count2),
        .wrap_cnt  (wrap_cnt2),
        .err       (err2),
        .ovf       (ovf2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One sample per call; returns 1 time unit after the edge that took it.
    task automatic send(input int v);
        in_valid = 1'b1;
        in_count = 4'(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_run(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) send(v);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        evt_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_kind",  int'(evt_kind),  0);
        chk("rst_evt_count", int'(evt_count), 0);
        chk("rst_wrap_cnt",  int'(wrap_cnt),  0);
        chk("rst_err",       int'(err),       0);
        chk("rst_ovf",       int'(ovf),       0);

        // Clean count 0..7, 0, 1 -> one WRAP
        send_run(0, 7);
        chk("pre_wrap_valid", int'(evt_valid), 0);
        send(0);
        chk("wrap_valid", int'(evt_valid), 1);
        chk("wrap_kind",  int'(evt_kind),  1);
        chk("wrap_count", int'(evt_count), 0);
        chk("wrap_cnt1",  int'(wrap_cnt),  1);
        send(1);
        chk("wrap_popped", int'(evt_valid), 0);
        chk("wrap_err",    int'(err),       0);
        // A gap with in_valid=0 is not a missed step
        @(posedge clk); #1;
        send(2);
        chk("gap_no_err", int'(err), 0);

        // Step error 3,4,6
        do_reset();
        send(3); send(4); send(6);
        chk("step_valid", int'(evt_valid), 1);
        chk("step_kind",  int'(evt_kind),  2);
        chk("step_count", int'(evt_count), 6);
        chk("step_err",   int'(err),       1);
        chk("step_state", int'(dut.state_reg), int'(ST_FAULT));
        send(7);
        chk("fault_ignored", int'(evt_valid), 0);
        @(posedge clk); #1;
        chk("fault_still_empty", int'(evt_valid), 0);

        // Range error straight out of reset
        do_reset();
        send(9);
        chk("range_valid", int'(evt_valid), 1);
        chk("range_kind",  int'(evt_kind),  3);
        chk("range_count", int'(evt_count), 9);
        chk("range_err",   int'(err),       1);

        // Range beats step: prev=7, sample 8 (also != expected 0)
        do_reset();
        send(7); send(8);
        chk("prio_kind",  int'(evt_kind),  3);
        chk("prio_count", int'(evt_count), 8);

        // Backpressure: fill with 4 wraps
        do_reset();
        evt_ready = 1'b0;
        send(0);
        for (int w = 0; w < 4; w++) begin
            send_run(1, 7);
            send(0);
        end
        chk("full_valid", int'(evt_valid), 1);
        chk("full_ovf",   int'(ovf),       0);
        chk("full_wrap",  int'(wrap_cnt),  4);
        chk("full_kind",  int'(evt_kind),  1);
        // 5th wrap lands with a pop in the same cycle -> accepted
        send_run(1, 7);
        evt_ready = 1'b1;
        send(0);
        evt_ready = 1'b0;
        chk("full_pop_ovf",  int'(ovf),      0);
        chk("full_pop_wrap", int'(wrap_cnt), 5);
        // 6th wrap with no pop -> dropped
        send_run(1, 7);
        send(0);
        chk("drop_ovf",   int'(ovf),       1);
        chk("drop_wrap",  int'(wrap_cnt),  6);
        chk("sat_wrap2",  int'(wrap_cnt2), 3);
        chk("hold_valid", int'(evt_valid), 1);
        chk("hold_kind",  int'(evt_kind),  1);
        chk("hold_count", int'(evt_count), 0);
        evt_ready = 1'b1;
        pops = 0;
        repeat (12) begin
            @(negedge clk);
            if (evt_valid) pops++;
            @(posedge clk);
        end
        #1;
        chk("drain_pops",  pops,             4);
        chk("drain_empty", int'(evt_valid),  0);

        // Reset with 2 queued events and err set
        do_reset();
        evt_ready = 1'b0;
        send_run(0, 7);
        send(0);
        send(3);
        chk("pre_rst_err",   int'(err),       1);
        chk("pre_rst_valid", int'(evt_valid), 1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_count = 4'd9;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("mid_rst_valid", int'(evt_valid), 0);
        chk("mid_rst_err",   int'(err),       0);
        chk("mid_rst_ovf",   int'(ovf),       0);
        chk("mid_rst_wrap",  int'(wrap_cnt),  0);
        chk("mid_rst_state", int'(dut.state_reg), int'(ST_IDLE));
        @(posedge clk); #1;
        chk("post_rst_valid", int'(evt_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
